// File: rtl/sample_unpacker.sv
`timescale 1ns/1ps
// Splits two-sample source words into single samples through a small FIFO,
// using a four-phase req/ack handshake on each side.
module sample_unpacker #(
  parameter int DWIDTH     = 16,
  parameter int DDWIDTH    = 2*DWIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int AWIDTH     = $clog2(FIFO_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                req_in,
  input  logic                ack_in,
  input  logic [0:DDWIDTH-1]  data_in,
  input  logic                req_out,
  output logic                ack_out,
  output logic [0:DWIDTH-1]   data_out,
  output logic [AWIDTH:0]     fill
);

  typedef enum logic [1:0] {IN_IDLE, IN_REQ, IN_WAIT} in_state_t;
  typedef enum logic       {OUT_IDLE, OUT_ACK}        out_state_t;

  localparam logic [AWIDTH:0]   DEPTH   = (AWIDTH+1)'(FIFO_DEPTH);
  localparam logic [AWIDTH:0]   TWO     = (AWIDTH+1)'(2);
  localparam logic [AWIDTH:0]   ONE     = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);

  logic [0:DWIDTH-1] mem_q [FIFO_DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q;
  logic [AWIDTH-1:0] rd_ptr_q;
  logic [AWIDTH:0]   fill_q;
  logic [AWIDTH:0]   fill_d;
  in_state_t         in_state_q;
  out_state_t        out_state_q;
  logic              req_in_q;
  logic              ack_out_q;
  logic [0:DWIDTH-1] data_out_q;
  logic              push;
  logic              pop;
  logic              room_for_word;

  // A push only happens from IN_REQ and a pop only from a non-empty FIFO,
  // so the FIFO can neither overflow nor underflow.
  assign push          = !rst && (in_state_q == IN_REQ) && ack_in;
  assign pop           = !rst && (out_state_q == OUT_IDLE) && req_out && (fill_q != '0);
  assign room_for_word = (DEPTH - fill_q) >= TWO;

  always_comb begin
    fill_d = fill_q;
    if (push) fill_d = fill_d + TWO;
    if (pop)  fill_d = fill_d - ONE;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]           <= data_in[0:DWIDTH-1];
      mem_q[wr_ptr_q + PTR_ONE] <= data_in[DWIDTH:DDWIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) fill_q <= '0;
    else     fill_q <= fill_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state_q <= IN_IDLE;
      req_in_q   <= 1'b0;
      wr_ptr_q   <= '0;
    end else begin
      case (in_state_q)
        IN_IDLE: begin
          if (!ack_in && room_for_word) begin
            in_state_q <= IN_REQ;
            req_in_q   <= 1'b1;
          end
        end
        IN_REQ: begin
          if (ack_in) begin
            wr_ptr_q   <= wr_ptr_q + AWIDTH'(2);
            req_in_q   <= 1'b0;
            in_state_q <= IN_WAIT;
          end
        end
        IN_WAIT: begin
          if (!ack_in) in_state_q <= IN_IDLE;
        end
        default: begin
          in_state_q <= IN_IDLE;
          req_in_q   <= 1'b0;
        end
      endcase
    end
  end

  // data_out is left untouched on release so it holds the last sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state_q <= OUT_IDLE;
      ack_out_q   <= 1'b0;
      data_out_q  <= '0;
      rd_ptr_q    <= '0;
    end else begin
      case (out_state_q)
        OUT_IDLE: begin
          if (pop) begin
            data_out_q  <= mem_q[rd_ptr_q];
            rd_ptr_q    <= rd_ptr_q + PTR_ONE;
            ack_out_q   <= 1'b1;
            out_state_q <= OUT_ACK;
          end
        end
        OUT_ACK: begin
          if (!req_out) begin
            ack_out_q   <= 1'b0;
            out_state_q <= OUT_IDLE;
          end
        end
        default: begin
          out_state_q <= OUT_IDLE;
          ack_out_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_in   = req_in_q;
  assign ack_out  = ack_out_q;
  assign data_out = data_out_q;
  assign fill     = fill_q;

endmodule

// File: tb/tb_sample_unpacker.sv
`timescale 1ns/1ps
// Directed bench for sample_unpacker: handshakes, ordering, full/empty, reset.
module tb_sample_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_in;
  logic        ack_in;
  logic [0:31] data_in;
  logic        req_out;
  logic        ack_out;
  logic [0:15] data_out;
  logic [3:0]  fill;

  int errors = 0;
  int checks = 0;

  sample_unpacker #(.DWIDTH(16), .DDWIDTH(32), .FIFO_DEPTH(8), .AWIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .req_in(req_in), .ack_in(ack_in), .data_in(data_in),
    .req_out(req_out), .ack_out(ack_out), .data_out(data_out),
    .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Source side: wait for req_in, present the word for one cycle.
  task automatic src_word(input logic [31:0] w, output bit ok);
    int t;
    t  = 0;
    ok = 1'b0;
    while (!req_in && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (req_in) begin
      data_in = w;
      ack_in  = 1'b1;
      @(negedge clk);
      check("src_req_drop", {31'b0, req_in}, 32'd0);
      ack_in = 1'b0;
      ok     = 1'b1;
    end
  endtask

  task automatic snk_sample(input logic [15:0] exp, input string tag);
    int t;
    req_out = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!ack_out && t < 40);
    check({tag, "_ack"}, {31'b0, ack_out}, 32'd1);
    check(tag, {16'b0, data_out}, {16'b0, exp});
    req_out = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (ack_out && t < 10);
    check({tag, "_rel"}, {31'b0, ack_out}, 32'd0);
  endtask

  // Fill-delta monitor for cycles where a push and a pop coincide.
  bit         mon_en = 1'b0;
  bit         prev_both = 1'b0;
  logic [3:0] prev_fill = '0;
  int         both_cnt = 0;

  always @(posedge clk) begin
    prev_both = mon_en && req_in && ack_in && !ack_out && req_out && (fill != 4'd0);
    prev_fill = fill;
  end

  always @(negedge clk) begin
    if (prev_both) begin
      check("fill_pushpop", {28'b0, fill}, {28'b0, prev_fill} + 32'd1);
      both_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    rst = 1'b1; ack_in = 1'b0; req_out = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_req_in",   {31'b0, req_in},   32'd0);
    check("rst_ack_out",  {31'b0, ack_out},  32'd0);
    check("rst_data_out", {16'b0, data_out}, 32'd0);
    check("rst_fill",     {28'b0, fill},     32'd0);

    // Single word with consumer idle.
    rst = 1'b0;
    @(negedge clk);
    check("t1_req_rise", {31'b0, req_in}, 32'd1);
    data_in = 32'h0001_FFFF;
    ack_in  = 1'b1;
    @(negedge clk);
    check("t1_req_drop", {31'b0, req_in}, 32'd0);
    check("t1_fill2",    {28'b0, fill},   32'd2);
    repeat (3) @(negedge clk);
    check("t1_req_held", {31'b0, req_in}, 32'd0);
    ack_in = 1'b0;

    // Consumer takes both samples; a third request stays pending.
    snk_sample(16'h0001, "t2_s0");
    check("t2_fill1", {28'b0, fill}, 32'd1);
    snk_sample(16'hFFFF, "t2_s1");
    check("t2_fill0", {28'b0, fill}, 32'd0);
    req_out = 1'b1;
    repeat (5) @(negedge clk);
    check("t2_noack_empty", {31'b0, ack_out}, 32'd0);
    req_out = 1'b0;
    @(negedge clk);

    // Fill the FIFO with the consumer stalled.
    n = 0;
    for (int i = 0; i < 6; i++) begin
      src_word(32'h0010_0011 + i * 32'h0002_0002, ok);
      if (!ok) break;
      n++;
    end
    check("t3_words", n, 32'd4);
    check("t3_fill8", {28'b0, fill},   32'd8);
    check("t3_req0",  {31'b0, req_in}, 32'd0);
    snk_sample(16'h0010, "t3_d0");
    check("t3_req_hold", {31'b0, req_in}, 32'd0);
    snk_sample(16'h0011, "t3_d1");
    check("t3_req_re", {31'b0, req_in}, 32'd1);
    for (int k = 2; k < 8; k++) snk_sample(16'h0010 + 16'(k), $sformatf("t3_d%0d", k));
    check("t3_fill0", {28'b0, fill}, 32'd0);

    // Consumer waiting on an empty FIFO.
    req_out = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_wait_empty", {31'b0, ack_out}, 32'd0);
    check("t4_req_in",     {31'b0, req_in},  32'd1);
    data_in = 32'h7FFF_8000;
    ack_in  = 1'b1;
    @(negedge clk);
    check("t4_ack_t1", {31'b0, ack_out}, 32'd0);
    ack_in = 1'b0;
    @(negedge clk);
    check("t4_ack_t2",  {31'b0, ack_out},  32'd1);
    check("t4_data_s0", {16'b0, data_out}, 32'h7FFF);
    req_out = 1'b0;
    @(negedge clk);
    check("t4_rel", {31'b0, ack_out}, 32'd0);
    snk_sample(16'h8000, "t4_s1");

    // Continuous traffic, 100 words through with wrap-around.
    mon_en = 1'b1;
    fork
      begin
        bit ok5;
        for (int i = 0; i < 100; i++) begin
          src_word({16'h1000 + 16'(2*i), 16'h1000 + 16'(2*i+1)}, ok5);
          check("t5_src_ok", {31'b0, ok5}, 32'd1);
          repeat (i % 3) @(negedge clk);
        end
      end
      begin
        for (int j = 0; j < 200; j++) snk_sample(16'h1000 + 16'(j), "t5_data");
      end
    join
    mon_en = 1'b0;
    @(negedge clk);
    check("t5_pushpop_seen", {31'b0, both_cnt != 0}, 32'd1);
    check("t5_fill0", {28'b0, fill}, 32'd0);

    // Reset with fill=5 and both handshakes mid-phase.
    for (int i = 0; i < 3; i++) begin
      src_word(32'hA000_0001 + 32'(i), ok);
      check("t6_src_ok", {31'b0, ok}, 32'd1);
    end
    check("t6_fill6", {28'b0, fill}, 32'd6);
    repeat (2) @(negedge clk);
    req_out = 1'b1;
    @(negedge clk);
    check("t6_fill5",    {28'b0, fill},    32'd5);
    check("t6_ack_mid",  {31'b0, ack_out}, 32'd1);
    check("t6_req_mid",  {31'b0, req_in},  32'd1);
    rst     = 1'b1;
    ack_in  = 1'b1;
    data_in = 32'h5555_6666;
    @(negedge clk);
    check("t6_rst_req_in",   {31'b0, req_in},   32'd0);
    check("t6_rst_ack_out",  {31'b0, ack_out},  32'd0);
    check("t6_rst_data_out", {16'b0, data_out}, 32'd0);
    check("t6_rst_fill",     {28'b0, fill},     32'd0);
    ack_in  = 1'b0;
    req_out = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    src_word(32'hABCD_1234, ok);
    check("t6_new_ok", {31'b0, ok}, 32'd1);
    snk_sample(16'hABCD, "t6_s0");
    snk_sample(16'h1234, "t6_s1");
    check("t6_fill0", {28'b0, fill}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
